// File: rtl/pc_ctrl_pkg.sv
// Shared fetch-side types and defaults for the program-counter controller.
package ifetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } pc_state_t;

  localparam int          XLEN_DEFAULT         = 32;
  localparam int          INSTR_BYTES          = 4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_ctrl_if.sv
// Fetch-address bus between the PC controller (master) and the fetch/decode side (slave).
import ifetch_pkg::*;

interface pc_ctrl_if #(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic [XLEN-1:0] target;
  logic            fetch_valid;
  logic            flush;
  logic            deq;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;

  modport master (
    output target, fetch_valid, flush,
    input  deq, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  target, fetch_valid, flush,
    output deq, redirect_valid, redirect_pc, halt
  );

endinterface

// File: rtl/pc_ctrl_occ_counter.sv
// Saturating up/down occupancy counter (0..MAX) with synchronous clear.
import ifetch_pkg::*;

module occ_counter #(
  parameter int MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       inc_i,
  input  logic                       dec_i,
  output logic [$clog2(MAX+1)-1:0]   cnt_o
);

  localparam int            W     = $clog2(MAX + 1);
  localparam logic [W-1:0]  MAX_W = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         incEff;
  logic         decEff;

  // A decrement at zero is dropped; an increment at MAX only lands if paired with a decrement.
  always_comb begin
    cnt_d  = cnt_q;
    decEff = dec_i && (cnt_q != '0);
    incEff = inc_i && ((cnt_q != MAX_W) || decEff);
    if (clr_i) begin
      cnt_d = '0;
    end else if (incEff && !decEff) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!incEff && decEff) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: issues sequential fetches into a bounded FIFO,
// handles redirects with a one-cycle flush, and stalls on halt or full.
import ifetch_pkg::*;

module pc_ctrl #(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int              FIFO_DEPTH   = 4
) (
  input logic        clk,
  input logic        rst_n,
  pc_ctrl_if.master  bus
);

  localparam int              CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]   DEPTH_W = CW'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

  pc_state_t       state_q;
  logic [XLEN-1:0] pc_q;
  logic            flush_q;
  logic [CW-1:0]   cnt;
  logic            fetchValid;
  logic            cntDec;
  logic [XLEN-1:0] alignedRedirect;
  logic            unused_redirect_lsbs;

  // A full FIFO can still take a fetch when an entry leaves in the same cycle.
  always_comb begin
    fetchValid = (state_q == RUN) && !bus.redirect_valid && !bus.halt &&
                 ((cnt < DEPTH_W) || bus.deq);
    cntDec     = bus.deq && (state_q != FLUSH);
  end

  assign alignedRedirect      = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  occ_counter #(
    .MAX (FIFO_DEPTH)
  ) u_occ (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (bus.redirect_valid),
    .inc_i (fetchValid),
    .dec_i (cntDec),
    .cnt_o (cnt)
  );

  // Redirect wins over everything; otherwise every state settles into RUN or HALT by the halt level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      flush_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      state_q <= FLUSH;
      pc_q    <= alignedRedirect;
      flush_q <= 1'b1;
    end else begin
      flush_q <= 1'b0;
      state_q <= bus.halt ? HALT : RUN;
      if (fetchValid) begin
        pc_q <= pc_q + PC_STEP;
      end
    end
  end

  assign bus.target      = pc_q;
  assign bus.fetch_valid = fetchValid;
  assign bus.flush       = flush_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: expected fetch/flush events are queued up front and a negedge monitor retires them.
module tb_pc_ctrl;

  typedef struct packed {
    logic        isFlush;
    logic [31:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t expQ[$];
  exp_t monItem;
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 clk = ~clk;

  pc_ctrl_if #(.XLEN(32)) bus ();

  pc_ctrl #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tally(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (ok) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic checkOutput(input string name, input logic fv, input logic fl, input logic [31:0] tgt);
    tally({name, "_flags"}, {bus.fetch_valid, bus.flush} === {fv, fl},
          64'({bus.fetch_valid, bus.flush}), 64'({fv, fl}));
    tally({name, "_target"}, bus.target === tgt, 64'(bus.target), 64'(tgt));
  endtask

  task automatic checkQueue(input string name);
    tally({name, "_all_events_seen"}, expQ.size() == 0, 64'(expQ.size()), 64'd0);
  endtask

  task automatic applyStimulus(input logic deq, input logic halt, input logic rv, input logic [31:0] rpc);
    bus.deq            = deq;
    bus.halt           = halt;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushFetch(input logic [31:0] a);
    expQ.push_back('{isFlush: 1'b0, addr: a});
  endtask

  task automatic pushFlush(input logic [31:0] a);
    expQ.push_back('{isFlush: 1'b1, addr: a});
  endtask

  // Called just after reset release: one BOOT cycle, four fetches, then full.
  task automatic bootSequence(input string tag);
    @(negedge clk);
    checkOutput({tag, "_boot"}, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) pushFetch(32'(i * 4));
    repeat (5) tick();
    @(negedge clk);
    checkOutput({tag, "_full_hold"}, 1'b0, 1'b0, 32'h10);
    tick();
    @(negedge clk);
    checkOutput({tag, "_full_hold2"}, 1'b0, 1'b0, 32'h10);
    checkQueue(tag);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus.fetch_valid === 1'b1 || bus.flush === 1'b1)) begin
      if (expQ.size() == 0) begin
        tally("unexpected_event", 1'b0, 64'({bus.flush, bus.target}), 64'd0);
      end else begin
        monItem = expQ.pop_front();
        tally(monItem.isFlush ? "flush_event" : "fetch_event",
              {bus.flush, bus.fetch_valid, bus.target} === {monItem.isFlush, ~monItem.isFlush, monItem.addr},
              64'({bus.flush, bus.fetch_valid, bus.target}),
              64'({monItem.isFlush, ~monItem.isFlush, monItem.addr}));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Halt-phase rows {deq, halt}: drains 4 -> 0, including a deq at zero that must be ignored.
  logic [1:0] haltRows [8] = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b11, 2'b00};

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) tick();
    checkOutput("reset_state", 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    bootSequence("boot1");

    // Full FIFO with continuous deq keeps fetching.
    pushFetch(32'h10); pushFetch(32'h14); pushFetch(32'h18);
    tick(); applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    tick(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("full_again", 1'b0, 1'b0, 32'h1C);
    checkQueue("full_deq");

    // Drop to cnt=3 via a halted deq, then redirect.
    tick(); applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk); checkOutput("halt_deq", 1'b0, 1'b0, 32'h1C);
    tick(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); checkOutput("halt_state", 1'b0, 1'b0, 32'h1C);
    tick(); applyStimulus(1'b0, 1'b0, 1'b1, 32'h8000_0103);
    @(negedge clk); checkOutput("redirect_cycle", 1'b0, 1'b0, 32'h1C);
    pushFlush(32'h8000_0100);
    for (int i = 0; i < 4; i++) pushFetch(32'h8000_0100 + 32'(i * 4));
    tick(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (5) tick();
    @(negedge clk);
    checkOutput("post_redirect_full", 1'b0, 1'b0, 32'h8000_0110);
    checkQueue("redirect");

    // Halt while draining; target must hold throughout.
    for (int i = 0; i < 8; i++) begin
      tick(); applyStimulus(haltRows[i][1], haltRows[i][0], 1'b0, 32'h0);
      @(negedge clk);
      checkOutput($sformatf("halt_drain%0d", i), 1'b0, 1'b0, 32'h8000_0110);
    end
    for (int i = 0; i < 4; i++) pushFetch(32'h8000_0110 + 32'(i * 4));
    repeat (5) tick();
    @(negedge clk);
    checkOutput("drain_refill", 1'b0, 1'b0, 32'h8000_0120);
    checkQueue("halt_drain");

    // Back-to-back redirects (second one inside FLUSH) and PC wrap.
    tick(); applyStimulus(1'b0, 1'b0, 1'b1, 32'h1234_5679);
    @(negedge clk); checkOutput("redirect2", 1'b0, 1'b0, 32'h8000_0120);
    pushFlush(32'h1234_5678); pushFlush(32'hFFFF_FFFC);
    pushFetch(32'hFFFF_FFFC); pushFetch(32'h0); pushFetch(32'h4); pushFetch(32'h8);
    tick(); applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    tick(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (5) tick();
    @(negedge clk);
    checkOutput("wrap_hold", 1'b0, 1'b0, 32'hC);
    checkQueue("wrap");

    // FLUSH with halt high goes to HALT, not RUN.
    tick(); applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    pushFlush(32'h100);
    tick(); applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    tick(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); checkOutput("flush_to_halt", 1'b0, 1'b0, 32'h100);
    for (int i = 0; i < 4; i++) pushFetch(32'h100 + 32'(i * 4));
    repeat (5) tick();
    @(negedge clk);
    checkOutput("halt_resume_full", 1'b0, 1'b0, 32'h110);
    checkQueue("flush_halt");

    // Reset asserted in the middle of FLUSH.
    tick(); applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0040);
    pushFlush(32'h40);
    tick(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_in_flush", 1'b0, 1'b0, 32'h0);
    checkQueue("pre_reset");
    tick();
    checkOutput("reset_held", 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    bootSequence("boot2");

    checkQueue("final");
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter XLEN, default 32, address/data width.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter FIFO_DEPTH, default 4, entries in the downstream fetch-to-decode FIFO.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 target  output  XLEN  fetch address driven to the instruction fetch stage.
REQ-007 fetch_valid  output  1  target is a real fetch this cycle; one FIFO push.
REQ-008 flush  output  1  clears the fetch-to-decode FIFO.
REQ-009 deq  input  1  one FIFO entry consumed this cycle (data_valid && ok).
REQ-010 redirect_valid  input  1  control-flow redirect request.
REQ-011 redirect_pc  input  XLEN  redirect destination.
REQ-012 halt  input  1  level request to stop fetching.

Function
REQ-013 The FSM SHALL have states BOOT, RUN, FLUSH and HALT.
REQ-014 Exiting reset, BOOT SHALL last exactly one cycle, with fetch_valid=0, then go to HALT if halt=1, otherwise to RUN.
REQ-015 An occupancy counter cnt (0..FIFO_DEPTH, width clog2(FIFO_DEPTH+1)) SHALL track the in-flight FIFO entries.
REQ-016 fetch_valid SHALL be combinational: 1 iff state==RUN, redirect_valid=0, halt=0, and (cnt<FIFO_DEPTH or deq=1).
REQ-017 In every state other than FLUSH, cnt SHALL update as cnt + fetch_valid - deq.
REQ-018 A deq while cnt==0 SHALL be ignored; cnt saturates at 0.
REQ-019 On a fetch_valid cycle the PC register SHALL advance by 4 next cycle, wrapping modulo 2^XLEN.
REQ-020 target SHALL equal the PC register at all times; it holds when fetch_valid=0.
REQ-021 Redirect SHALL have priority over halt, full and deq.
REQ-022 On redirect_valid=1 in RUN, HALT or BOOT, the next state SHALL be FLUSH with PC <= {redirect_pc[XLEN-1:2],2'b00} and cnt <= 0.
REQ-023 flush SHALL be 1 only in FLUSH (registered); fetch_valid=0 and deq is ignored in FLUSH.
REQ-024 FLUSH SHALL last one cycle, then go to HALT if halt=1, otherwise to RUN.
REQ-025 A redirect_valid during FLUSH SHALL reload the PC and stay in FLUSH one more cycle.
REQ-026 halt=1 in RUN without a redirect SHALL move to HALT next cycle; HALT returns to RUN the cycle after halt=0.
REQ-027 In HALT, deq SHALL still decrement cnt, so the FIFO drains.
REQ-028 When cnt==FIFO_DEPTH and deq=0, the PC and target SHALL hold and no fetch is issued; the FIFO never overflows.

Reset
REQ-029 While rst_n=0: state=BOOT, PC=RESET_VECTOR, cnt=0, flush=0, fetch_valid=0, all asynchronously.
REQ-030 Reset mid-operation, including in FLUSH or at full, SHALL discard all state; no flush is generated on reset exit.

Structure
REQ-031 Package ifetch_pkg SHALL hold: the pc_state_t enum (BOOT, RUN, FLUSH, HALT), the XLEN default, INSTR_BYTES=4 and the RESET_VECTOR default.
REQ-032 One sub-module, occ_counter, is natural: a saturating up/down counter with synchronous clear; everything else stays inline.

Verification
REQ-033 Reset release, halt=0, deq=0, DEPTH=4 -> BOOT 1 cycle, then fetch_valid for 4 cycles with targets 0x0, 0x4, 0x8, 0xC; then target holds at 0x10 with fetch_valid=0.
REQ-034 FIFO full, then deq=1 continuously -> fetch_valid=1 every cycle, cnt stays 4, targets 0x10, 0x14, 0x18.
REQ-035 redirect_valid=1, redirect_pc=0x8000_0103, cnt=3 -> that cycle fetch_valid=0; next cycle flush=1, cnt=0, target=0x8000_0100; following cycle fetch_valid=1 at 0x8000_0100.
REQ-036 PC=0xFFFF_FFFC, fetch_valid=1 -> next target=0x0000_0000.
REQ-037 halt=1 with cnt=2 and deq pulsed twice -> fetch_valid=0 throughout, cnt reaches 0; halt=0 -> RUN, fetch resumes at the held target.
REQ-038 rst_n asserted during FLUSH -> flush=0 and target=RESET_VECTOR immediately; on release the BOOT sequence is identical to REQ-033.
